// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm
// Purpose  : Multicycle MIPS-subset control sequencer (22-state Moore FSM).
//            Optional retired-instruction counter enabled by CTRL_FSM_INSTR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [4:0]  state,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,  S_DECODE  = 5'd1,  S_MEMADR  = 5'd2,  S_LW_RD   = 5'd3,
        S_LD_WB   = 5'd4,  S_SW_WR   = 5'd5,  S_ADDU_EX = 5'd6,  S_RT_WB   = 5'd7,
        S_BEQ     = 5'd8,  S_JAL     = 5'd9,  S_SUBU_EX = 5'd10, S_SLT_EX  = 5'd11,
        S_JR      = 5'd12, S_ORI_EX  = 5'd13, S_LUI_EX  = 5'd14, S_J       = 5'd15,
        S_LB_RD   = 5'd16, S_SB_WR   = 5'd17, S_IT_WB   = 5'd18, S_SLTI_EX = 5'd19,
        S_UNUSED  = 5'd20, S_ADDI_EX = 5'd21
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW, OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_ORI:                     state_d = S_ORI_EX;
                    OP_LUI:                     state_d = S_LUI_EX;
                    OP_ADDI, OP_ADDIU:          state_d = S_ADDI_EX;
                    OP_SLTI:                    state_d = S_SLTI_EX;
                    OP_BEQ:                     state_d = S_BEQ;
                    OP_J:                       state_d = S_J;
                    OP_JAL:                     state_d = S_JAL;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADDU: state_d = S_ADDU_EX;
                            FN_SUBU: state_d = S_SUBU_EX;
                            FN_SLT:  state_d = S_SLT_EX;
                            FN_JR:   state_d = S_JR;
                            default: illegal_d = 1'b1;
                        endcase
                    end
                    default:                    illegal_d = 1'b1;
                endcase
            end
            // op is held by the IR, so it still selects the memory variant here
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_d = S_LW_RD;
                    OP_SW:   state_d = S_SW_WR;
                    OP_LB:   state_d = S_LB_RD;
                    OP_SB:   state_d = S_SB_WR;
                    default: illegal_d = 1'b1;
                endcase
            end
            S_LW_RD, S_LB_RD:                          state_d = S_LD_WB;
            S_ADDU_EX, S_SUBU_EX, S_SLT_EX:            state_d = S_RT_WB;
            S_ORI_EX, S_LUI_EX, S_SLTI_EX, S_ADDI_EX:  state_d = S_IT_WB;
            S_LD_WB, S_SW_WR, S_SB_WR, S_RT_WB, S_IT_WB,
            S_BEQ, S_JAL, S_JR, S_J, S_UNUSED:         state_d = S_FETCH;
            default:                                   illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

`ifdef CTRL_FSM_INSTR_CNT_EN
    logic        retire_w;
    logic [31:0] instr_cnt_q;

    // A completed instruction is any return to fetch that is not an abort
    assign retire_w = (state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt_q <= 32'd0;
        end else if (retire_w) begin
            instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign instr_cnt = instr_cnt_q;
`else
    assign instr_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// Testbench for ctrl_fsm: directed and random instructions checked against a
// per-instruction state-path model.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  state;
    logic        illegal;
    logic [31:0] instr_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt;
    bit          cnt_en;

    ctrl_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .state     (state),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // Legal instructions as {op, funct}
    logic [11:0] legal_tbl [19] = '{
        {6'b100011, 6'b0}, {6'b101011, 6'b0}, {6'b100000, 6'b0}, {6'b101000, 6'b0},
        {6'b001101, 6'b0}, {6'b001111, 6'b0}, {6'b001000, 6'b0}, {6'b001001, 6'b0},
        {6'b001010, 6'b0}, {6'b000100, 6'b0}, {6'b000010, 6'b0}, {6'b000011, 6'b0},
        {6'b000000, 6'b100001}, {6'b000000, 6'b100011}, {6'b000000, 6'b101010},
        {6'b000000, 6'b001000}, {6'b100011, 6'b111111}, {6'b001111, 6'b101010},
        {6'b000011, 6'b000001}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full state path after fetch, ending in the return to state 0
    function automatic int model_path(input logic [5:0] o, input logic [5:0] f,
                                      output int p[6], output bit ill);
        ill = 1'b0;
        p   = '{0, 0, 0, 0, 0, 0};
        case (o)
            6'b100011: begin p = '{1, 2, 3, 4, 0, 0};   return 5; end
            6'b100000: begin p = '{1, 2, 16, 4, 0, 0};  return 5; end
            6'b101011: begin p = '{1, 2, 5, 0, 0, 0};   return 4; end
            6'b101000: begin p = '{1, 2, 17, 0, 0, 0};  return 4; end
            6'b001101: begin p = '{1, 13, 18, 0, 0, 0}; return 4; end
            6'b001111: begin p = '{1, 14, 18, 0, 0, 0}; return 4; end
            6'b001000,
            6'b001001: begin p = '{1, 21, 18, 0, 0, 0}; return 4; end
            6'b001010: begin p = '{1, 19, 18, 0, 0, 0}; return 4; end
            6'b000100: begin p = '{1, 8, 0, 0, 0, 0};   return 3; end
            6'b000010: begin p = '{1, 15, 0, 0, 0, 0};  return 3; end
            6'b000011: begin p = '{1, 9, 0, 0, 0, 0};   return 3; end
            6'b000000: begin
                case (f)
                    6'b100001: begin p = '{1, 6, 7, 0, 0, 0};  return 4; end
                    6'b100011: begin p = '{1, 10, 7, 0, 0, 0}; return 4; end
                    6'b101010: begin p = '{1, 11, 7, 0, 0, 0}; return 4; end
                    6'b001000: begin p = '{1, 12, 0, 0, 0, 0}; return 3; end
                    default:   begin p = '{1, 0, 0, 0, 0, 0}; ill = 1'b1; return 2; end
                endcase
            end
            default: begin p = '{1, 0, 0, 0, 0, 0}; ill = 1'b1; return 2; end
        endcase
    endfunction

    // Entered #1 after an edge with state 0; runs up to 'limit' cycles of the instruction
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int limit);
        int p[6];
        bit ill;
        int len;
        len   = model_path(o, f, p, ill);
        op    = o;
        funct = f;
        for (int i = 0; i < len && i < limit; i++) begin
            @(posedge clk);
            #1;
            if (i == len - 1 && !ill && cnt_en) model_cnt = model_cnt + 32'd1;
            check("state", {27'd0, state}, p[i]);
            check("illegal", {31'd0, illegal}, {31'd0, (ill && i == len - 1)});
            check("instr_cnt", instr_cnt, model_cnt);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            model_cnt = 32'd0;
            check("rst_state", {27'd0, state}, 32'd0);
            check("rst_illegal", {31'd0, illegal}, 32'd0);
            check("rst_instr_cnt", instr_cnt, 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] e;
        int          len;
`ifdef CTRL_FSM_INSTR_CNT_EN
        cnt_en = 1'b1;
`else
        cnt_en = 1'b0;
`endif
        model_cnt = 32'd0;
        op        = 6'd0;
        funct     = 6'd0;
        rst       = 1'b1;
        do_reset(2);

        // lw then sw
        run_instr(6'b100011, 6'd0, 99);
        run_instr(6'b101011, 6'd0, 99);
        // slt then lui
        run_instr(6'b000000, 6'b101010, 99);
        run_instr(6'b001111, 6'd0, 99);
        // jal, jr, beq twice
        run_instr(6'b000011, 6'd0, 99);
        run_instr(6'b000000, 6'b001000, 99);
        run_instr(6'b000100, 6'd0, 99);
        run_instr(6'b000100, 6'd0, 99);
        // illegal opcode and illegal funct
        run_instr(6'b111111, 6'd0, 99);
        run_instr(6'b000000, 6'b000000, 99);

        // reset held two cycles while sitting in state 7
        run_instr(6'b000000, 6'b100001, 3);
        do_reset(2);
        run_instr(6'b001101, 6'd0, 99);

        for (int k = 0; k < 19; k++) begin
            e = legal_tbl[k];
            run_instr(e[11:6], e[5:0], 99);
        end

`ifdef CTRL_FSM_INSTR_CNT_EN
        force dut.instr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt_q;
        model_cnt = 32'hFFFF_FFFF;
        check("preload", instr_cnt, model_cnt);
        run_instr(6'b000010, 6'd0, 99);
        check("wrap", instr_cnt, 32'd0);
`endif

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                e = 12'($urandom);
            end else begin
                e = legal_tbl[$urandom_range(0, 18)];
            end
            if ($urandom_range(0, 7) == 0) begin
                int pp[6];
                bit il;
                len = model_path(e[11:6], e[5:0], pp, il);
                run_instr(e[11:6], e[5:0], $urandom_range(1, len - 1));
                do_reset($urandom_range(1, 2));
            end else begin
                run_instr(e[11:6], e[5:0], 99);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Ports are named clk and rst.
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 op  input  6  opcode field IR[31:26]; valid from state 1 onward.
REQ-005 funct  input  6  function field IR[5:0]; used only when op = 000000.
REQ-006 state  output  5  current state code 0..21, registered; consumed by the control-signal decoder.
REQ-007 illegal  output  1  one-cycle pulse on an undecodable instruction, registered.
REQ-008 instr_cnt  output  32  retired-instruction count, registered; see Configuration.

Function
REQ-009 SHALL be a Moore FSM with 22 states (0..21), one transition per clk; state is updated on every clock edge.
REQ-010 State 0 (fetch) SHALL go to state 1 (decode) unconditionally.
REQ-011 Decode (state 1) next state SHALL be determined by op as follows:
- lw 100011, sw 101011, lb 100000, sb 101000 -> 2
- ori 001101 -> 13
- lui 001111 -> 14
- addi 001000 and addiu 001001 -> 21
- slti 001010 -> 19
- beq 000100 -> 8
- j 000010 -> 15
- jal 000011 -> 9
REQ-012 Decode with op = 000000 SHALL use funct as follows:
- addu 100001 -> 6
- subu 100011 -> 10
- slt 101010 -> 11
- jr 001000 -> 12
REQ-013 Any other op, or any other funct when op = 000000, SHALL go 1 -> 0 and assert illegal for exactly the cycle state = 0 that follows.
REQ-014 State 2 (address calculation) SHALL branch on op, which is held stable by the IR:
- lw -> 3
- sw -> 5
- lb -> 16
- sb -> 17
REQ-015 Load and store chains SHALL be:
- lw: 3 -> 4
- lb: 16 -> 4
- 4 -> 0
- 5 -> 0
- 17 -> 0
REQ-016 R-type chains SHALL be 6 -> 7, 10 -> 7, 11 -> 7, then 7 -> 0.
REQ-017 I-type ALU chains SHALL be 13 -> 18, 14 -> 18, 19 -> 18, 21 -> 18, then 18 -> 0.
REQ-018 States 8, 9, 12 and 15 SHALL go to 0 after one cycle, independent of the branch outcome.
REQ-019 State 20 SHALL be unused: it SHALL never be entered, and if it is reached it SHALL go to 0.
REQ-020 Out-of-range codes 22..31 SHALL go to 0 on the next edge and assert illegal.
REQ-021 Latency in cycles, counted from state 0 to the next state 0:
- lw and lb: 5
- sw, sb, R-type, and I-type ALU: 4
- beq, j, jal and jr: 3
- illegal: 2
REQ-022 The overflow condition SHALL NOT affect sequencing; write suppression is handled downstream.

Reset
REQ-023 When rst = 1 at a rising edge, the next values SHALL be state = 0, illegal = 0 and instr_cnt = 0.
REQ-024 Reset SHALL take priority over every transition, including reset asserted mid-instruction in any state.
REQ-025 On the first edge after rst deasserts, state SHALL go 0 -> 1.

Configuration
REQ-026 Macro CTRL_FSM_INSTR_CNT_EN.
REQ-027 With CTRL_FSM_INSTR_CNT_EN defined, instr_cnt SHALL increment by 1 on each transition from a nonzero state into state 0 that is not an illegal abort. The count SHALL wrap from 0xFFFFFFFF to 0, and the increment SHALL be visible in the same cycle that state becomes 0.
REQ-028 Without CTRL_FSM_INSTR_CNT_EN, the instr_cnt port SHALL remain present and be driven constant 0; no counter flops SHALL be synthesized.

Verification
REQ-029 Reset: hold rst = 1 for 2 cycles in state 7, then release -> state = 0, then 1; illegal = 0 and instr_cnt = 0 throughout reset.
REQ-030 lw then sw: op = 100011 followed by op = 101011 -> state sequence 0,1,2,3,4,0,1,2,5,0; with the macro enabled, instr_cnt = 2.
REQ-031 R-type and I-type: funct = 101010, then op = 001111 -> 0,1,11,7,0,1,14,18,0.
REQ-032 Jumps: op = 000011, then op = 000000 with funct = 001000, then op = 000100 -> 0,1,9,0,1,12,0,1,8,0; state 8 exits to 0 with both zero = 1 and zero = 0.
REQ-033 Illegal: op = 111111 -> 0,1,0 with a single-cycle illegal pulse and instr_cnt unchanged. op = 000000 with funct = 000000 SHALL give the same response.
REQ-034 Wrap: preload instr_cnt = 0xFFFFFFFF by force, then retire one j -> instr_cnt = 0. With the macro undefined, instr_cnt SHALL stay 0 for the whole run.
